// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match controller: state encoding and
// elaboration-time helpers used by the RTL and its bench.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    GAME_OVER = 3'd4
  } match_state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Converts up to 16 decimal digits; digits beyond the value come back zero.
  function automatic logic [63:0] bin2bcd(input int unsigned value);
    logic [63:0] result;
    int unsigned rem;
    result = '0;
    rem    = value;
    for (int d = 0; d < 16; d++) begin
      result[d*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Synchronous multi-digit BCD up-counter with clear; holds once every digit
// reads nine.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [DIGITS*4-1:0] bcd
);

  logic [DIGITS*4-1:0] bcd_next;
  logic                all_nines;
  logic                carry;

  // Ripple a decimal carry upward from the least-significant digit.
  always_comb begin
    bcd_next  = bcd;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (bcd[d*4 +: 4] == 4'd9) begin
          bcd_next[d*4 +: 4] = 4'd0;
        end else begin
          bcd_next[d*4 +: 4] = bcd[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      bcd <= '0;
    end else if (inc && !all_nines) begin
      bcd <= bcd_next;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, rally, pause and game-over, with
// per-player BCD scores and registered ball run/recentre controls.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 100_000_000,
  localparam int PW = (clog2(NUM_PLAYERS) > 1) ? clog2(NUM_PLAYERS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            pause,
  input  logic [NUM_PLAYERS-1:0]          score_evt,
  output logic                            ball_run,
  output logic                            ball_recentre,
  output logic [PW-1:0]                   serve_player,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] scores_bcd,
  output logic [PW-1:0]                   winner,
  output logic                            game_over,
  output logic [2:0]                      state_o
);

  localparam int BW = DIGITS * 4;
  localparam int CW = (clog2(SERVE_DELAY) > 1) ? clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY - 1);
  // A player already on this score wins with their next point.
  localparam logic [BW-1:0] MATCH_POINT_BCD = BW'(bin2bcd(WIN_SCORE - 1));

  generate
    if (NUM_PLAYERS < 2 || SERVE_DELAY < 1 || WIN_SCORE < 1 ||
        (bin2bcd(WIN_SCORE) >> BW) != 64'd0) begin : g_bad_params
      $error("pong_match_ctrl: illegal NUM_PLAYERS, WIN_SCORE or SERVE_DELAY");
    end
  endgenerate

  match_state_t           state, state_n;
  logic [CW-1:0]          serve_cnt, serve_cnt_n;
  logic                   start_q, pause_q, start_edge, pause_edge;
  logic [PW-1:0]          serve_player_n, winner_n, hit_idx;
  logic [NUM_PLAYERS-1:0] score_inc, first_hit;
  logic                   clear_scores, hit, hit_wins;
  logic                   ball_run_n, ball_recentre_n, game_over_n;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign state_o    = state;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    bcd_counter #(.DIGITS(DIGITS)) u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_scores),
      .inc   (score_inc[p]),
      .bcd   (scores_bcd[p*BW +: BW])
    );
  end

  // Edge registers reload on reset so a button held through reset stays quiet.
  always_ff @(posedge clk) begin
    start_q <= start;
    pause_q <= pause;
    if (reset) begin
      state         <= IDLE;
      serve_cnt     <= '0;
      serve_player  <= '0;
      winner        <= '0;
      ball_run      <= 1'b0;
      ball_recentre <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_n;
      serve_cnt     <= serve_cnt_n;
      serve_player  <= serve_player_n;
      winner        <= winner_n;
      ball_run      <= ball_run_n;
      ball_recentre <= ball_recentre_n;
      game_over     <= game_over_n;
    end
  end

  always_comb begin
    state_n        = state;
    serve_cnt_n    = serve_cnt;
    serve_player_n = serve_player;
    winner_n       = winner;
    clear_scores   = 1'b0;
    score_inc      = '0;
    hit            = 1'b0;
    hit_idx        = '0;
    hit_wins       = 1'b0;
    first_hit      = '0;

    // Scanning downward leaves the lowest-numbered scorer selected.
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (score_evt[i]) begin
        hit          = 1'b1;
        hit_idx      = PW'(i);
        hit_wins     = (scores_bcd[i*BW +: BW] == MATCH_POINT_BCD);
        first_hit    = '0;
        first_hit[i] = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_n     = SERVE;
          serve_cnt_n = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (serve_cnt == '0) state_n = PLAY;
        else                 serve_cnt_n = serve_cnt - CW'(1);
      end
      PLAY: begin
        if (hit) begin
          score_inc      = first_hit;
          serve_player_n = hit_idx;
          if (hit_wins) begin
            state_n  = GAME_OVER;
            winner_n = hit_idx;
          end else begin
            state_n     = SERVE;
            serve_cnt_n = SERVE_LOAD;
          end
        end else if (pause_edge) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (start_edge) begin
          clear_scores = 1'b1;
          state_n      = SERVE;
          serve_cnt_n  = SERVE_LOAD;
        end else if (pause_edge) begin
          state_n = PLAY;
        end
      end
      GAME_OVER: begin
        if (start_edge) begin
          clear_scores = 1'b1;
          winner_n     = '0;
          state_n      = SERVE;
          serve_cnt_n  = SERVE_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ball_run_n      = (state_n == PLAY);
    game_over_n     = (state_n == GAME_OVER);
    ball_recentre_n = (state_n == SERVE) && (state != SERVE);
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a small match model pushes expected
// output snapshots, popped and compared once the DUT has taken the stimulus.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  localparam int NP = 2;
  localparam int DG = 2;
  localparam int WS = 11;
  localparam int SD = 5;

  logic        clk = 1'b0;
  logic        reset, start, pause;
  logic [1:0]  score_evt;
  logic        ball_run, ball_recentre, serve_player, winner, game_over;
  logic [15:0] scores_bcd;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .NUM_PLAYERS (NP),
    .DIGITS      (DG),
    .WIN_SCORE   (WS),
    .SERVE_DELAY (SD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .score_evt     (score_evt),
    .ball_run      (ball_run),
    .ball_recentre (ball_recentre),
    .serve_player  (serve_player),
    .scores_bcd    (scores_bcd),
    .winner        (winner),
    .game_over     (game_over),
    .state_o       (state_o)
  );

  typedef struct packed {
    logic [15:0] scores;
    logic        sp;
    logic        win;
    logic        go;
    logic [2:0]  st;
    logic        run;
    logic        rec;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         model_score[NP];
  logic       model_sp, m_winner;
  logic [2:0] m_state;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = {scores_bcd, serve_player, winner, game_over, state_o, ball_run, ball_recentre};
    return o;
  endfunction

  function automatic exp_t model_exp(input logic [2:0] st, input logic run, input logic rec);
    exp_t e;
    logic [63:0] b;
    e = '0;
    for (int i = 0; i < NP; i++) begin
      b = bin2bcd(model_score[i]);
      e.scores[i*8 +: 8] = b[7:0];
    end
    e.sp  = model_sp;
    e.win = m_winner;
    e.go  = (st == GAME_OVER);
    e.st  = st;
    e.run = run;
    e.rec = rec;
    return e;
  endfunction

  task automatic drive_score(input logic [1:0] evt);
    int idx;
    idx = -1;
    for (int i = NP - 1; i >= 0; i--) if (evt[i]) idx = i;
    score_evt = evt;
    if (m_state == PLAY && idx >= 0) begin
      model_score[idx]++;
      model_sp = idx[0];
      if (model_score[idx] == WS) begin
        m_state  = GAME_OVER;
        m_winner = idx[0];
      end else begin
        m_state = SERVE;
      end
      exp_q.push_back(model_exp(m_state, 1'b0, m_state == SERVE));
    end else begin
      exp_q.push_back(model_exp(m_state, m_state == PLAY, 1'b0));
    end
    step();
    score_evt = '0;
  endtask

  task automatic press_start();
    start = 1'b1;
    if (m_state == IDLE || m_state == PAUSED || m_state == GAME_OVER) begin
      foreach (model_score[i]) model_score[i] = 0;
      m_winner = 1'b0;
      m_state  = SERVE;
      exp_q.push_back(model_exp(SERVE, 1'b0, 1'b1));
    end else begin
      exp_q.push_back(model_exp(m_state, m_state == PLAY, 1'b0));
    end
    step();
    start = 1'b0;
  endtask

  task automatic press_pause();
    pause = 1'b1;
    if (m_state == PLAY)        m_state = PAUSED;
    else if (m_state == PAUSED) m_state = PLAY;
    exp_q.push_back(model_exp(m_state, m_state == PLAY, 1'b0));
    step();
    pause = 1'b0;
  endtask

  task automatic wait_play(input string tag);
    int n;
    n = 0;
    while (ball_run !== 1'b1 && n < 4 * SD) begin
      step();
      n++;
    end
    checks++;
    if (ball_run !== 1'b1)
      $display("[TB] FAIL %s_serve_wait: ball_run=%b, required 1 within %0d cycles", tag, ball_run, 4 * SD);
    else passes++;
    m_state = PLAY;
  endtask

  task automatic test_reset();
    exp_t e, got;
    reset = 1'b1; start = 1'b0; pause = 1'b0; score_evt = '0;
    foreach (model_score[i]) model_score[i] = 0;
    model_sp = 1'b0; m_winner = 1'b0; m_state = IDLE;
    step();
    exp_q.push_back(model_exp(IDLE, 1'b0, 1'b0));
    step();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL reset_state: got %h required %h", got, e); else passes++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_start_serve();
    exp_t e, got;
    press_start();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL serve_entry: got %h required %h", got, e); else passes++;
    for (int c = 1; c <= SD; c++) begin
      step();
      checks++;
      if (ball_run !== (c == SD) || ball_recentre !== 1'b0)
        $display("[TB] FAIL serve_timing_c%0d: run=%b rec=%b required run=%b rec=0",
                 c, ball_run, ball_recentre, c == SD);
      else passes++;
    end
    m_state = PLAY;
    checks++;
    if (scores_bcd !== 16'h0000) $display("[TB] FAIL serve_scores: got %h required 0000", scores_bcd); else passes++;
  endtask

  task automatic test_bcd_carry();
    exp_t e, got;
    for (int n = 1; n <= 10; n++) begin
      drive_score(2'b10);
      e = exp_q.pop_front(); got = observed(); checks++;
      if (got !== e) $display("[TB] FAIL bcd_point%0d: got %h required %h", n, got, e); else passes++;
      wait_play("bcd");
    end
    checks++;
    if (scores_bcd !== 16'h1000 || serve_player !== 1'b1)
      $display("[TB] FAIL bcd_carry: scores=%h sp=%b required 1000 sp=1", scores_bcd, serve_player);
    else passes++;
  endtask

  task automatic test_simultaneous();
    exp_t e, got;
    drive_score(2'b11);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL simul_score: got %h required %h", got, e); else passes++;
    checks++;
    if (scores_bcd !== 16'h1001 || state_o !== 3'd1 || serve_player !== 1'b0)
      $display("[TB] FAIL simul_lowest: scores=%h st=%0d sp=%b required 1001 st=1 sp=0",
               scores_bcd, state_o, serve_player);
    else passes++;
    wait_play("simul");
  endtask

  task automatic test_pause();
    exp_t e, got;
    press_pause();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL pause_enter: got %h required %h", got, e); else passes++;
    drive_score(2'b01);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL pause_score_ignored: got %h required %h", got, e); else passes++;
    press_pause();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL pause_resume: got %h required %h", got, e); else passes++;
    drive_score(2'b01);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL pause_rally_score: got %h required %h", got, e); else passes++;
    press_pause();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL pause_in_serve: got %h required %h", got, e); else passes++;
    wait_play("pause");
    checks++;
    if (state_o !== 3'd2 || scores_bcd !== 16'h1002)
      $display("[TB] FAIL pause_after_serve: st=%0d scores=%h required st=2 scores=1002", state_o, scores_bcd);
    else passes++;
  endtask

  task automatic test_game_over();
    exp_t e, got;
    for (int n = 0; n < WS && model_score[0] < WS; n++) begin
      drive_score(2'b01);
      e = exp_q.pop_front(); got = observed(); checks++;
      if (got !== e) $display("[TB] FAIL gameover_point%0d: got %h required %h", n, got, e); else passes++;
      if (m_state == SERVE) wait_play("gameover");
    end
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || ball_run !== 1'b0 || scores_bcd !== 16'h1011)
      $display("[TB] FAIL gameover_flags: go=%b win=%b run=%b scores=%h required 1 0 0 1011",
               game_over, winner, ball_run, scores_bcd);
    else passes++;
    drive_score(2'b01);
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL gameover_hold: got %h required %h", got, e); else passes++;
    press_start();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL gameover_restart: got %h required %h", got, e); else passes++;
    wait_play("restart");
  endtask

  task automatic test_reset_mid_serve();
    exp_t e, got;
    for (int n = 0; n < 5; n++) begin
      drive_score(2'b01);
      e = exp_q.pop_front(); got = observed(); checks++;
      if (got !== e) $display("[TB] FAIL midreset_point%0d: got %h required %h", n, got, e); else passes++;
      if (n < 4) wait_play("midreset");
    end
    checks++;
    if (scores_bcd !== 16'h0005 || state_o !== 3'd1)
      $display("[TB] FAIL midreset_setup: scores=%h st=%0d required 0005 st=1", scores_bcd, state_o);
    else passes++;
    start = 1'b1;
    reset = 1'b1;
    foreach (model_score[i]) model_score[i] = 0;
    model_sp = 1'b0; m_winner = 1'b0; m_state = IDLE;
    exp_q.push_back(model_exp(IDLE, 1'b0, 1'b0));
    step();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL midreset_state: got %h required %h", got, e); else passes++;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (state_o !== 3'd0 || ball_recentre !== 1'b0)
      $display("[TB] FAIL held_start_quiet: st=%0d rec=%b required st=0 rec=0", state_o, ball_recentre);
    else passes++;
    start = 1'b0;
    step();
    press_start();
    e = exp_q.pop_front(); got = observed(); checks++;
    if (got !== e) $display("[TB] FAIL fresh_start_edge: got %h required %h", got, e); else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_start_serve();
    test_bcd_carry();
    test_simultaneous();
    test_pause();
    test_game_over();
    test_reset_mid_serve();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
